wb_ascon_master: RTL
====================

# wb_ascon_master

Wishbone initiator that drives the `wb_ASCON` register-mapped slave on behalf of on-chip logic. One `start` pulse launches a fixed job: load key, nonce, associated data and control word via Wishbone single writes, poll STATUS until the core reports done, then read back the data-out and tag registers. It sits between a local command source (CPU shim or DMA sequencer) and the ASCON slave's Wishbone port, replacing bench-driven register programming in integrated builds.

## Interface
- `POLL_LIMIT`, default 4096: maximum STATUS reads before the job aborts with `err`.
- `clk` in 1: system clock, all logic on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle job request; sampled only in IDLE.
- `key` in 128: key; word i = `key[32i+31:32i]`.
- `nonce` in 128: nonce, same word ordering.
- `ad` in 64: associated data, word i = `ad[32i+31:32i]`.
- `cntrl` in 16: control word, zero-extended to 32 bits for CNTRL.
- `busy` out 1: high from the cycle after accepted `start` until `done`.
- `done` out 1: one-cycle pulse at job end.
- `err` out 1: valid with `done`; 1 = poll timeout.
- `data_out` out 64: read result, word i from 0x30+4i.
- `tag` out 128: read result, word i from 0x38+4i.
- `wb_adr_o` out 32, `wb_dat_o` out 32, `wb_sel_o` out 4, `wb_we_o` out 1, `wb_cyc_o` out 1, `wb_stb_o` out 1: Wishbone master outputs.
- `wb_ack_i` in 1, `wb_dat_i` in 32: Wishbone slave responses.

## Operation
- Register map (byte addresses): STATUS 0x00 (bit0 = done), CNTRL 0x04, KEY0–3 0x08–0x14, NONCE0–3 0x18–0x24, AD0–1 0x28–0x2C, DOUT0–1 0x30–0x34, TAG0–3 0x38–0x44.
- FSM: IDLE → WRITE ↔ WGAP (11 writes in order KEY0..3, NONCE0..3, AD0..1, CNTRL) → POLL ↔ PGAP → READ ↔ RGAP (6 reads DOUT0,DOUT1,TAG0..3) → DONE → IDLE.
- Inputs latched into internal registers when `start` is accepted; later input changes do not affect the job.
- Every transaction: `wb_sel_o`=4'b1111; writes `wb_we_o`=1; reads `wb_we_o`=0, `wb_dat_o`=0.
- POLL: read 0x00; if `wb_dat_i[0]`=1 go READ, else PGAP then re-poll. Poll counter increments per completed poll; reaching `POLL_LIMIT` without done → DONE with `err`=1, no reads, `data_out`/`tag` unchanged.
- Read data captured into `data_out`/`tag` word on the ack cycle; results hold until overwritten by a later successful job.
- `start` while busy: ignored, no effect.

## Timing
- Reset values: all Wishbone outputs 0, `busy`=0, `done`=0, `err`=0, `data_out`=0, `tag`=0, FSM IDLE, counters 0.
- `start` high in IDLE at edge N: cycle N+1 `busy`=1, `wb_cyc_o`=`wb_stb_o`=1 with KEY0 address/data.
- Transaction handshake: cyc/stb/adr/dat/we held stable until the rising edge where `wb_ack_i`=1 is sampled; that edge completes it. Next cycle cyc=stb=0 (one gap cycle, GAP states), then next transaction asserts.
- Zero-wait slave (ack in first stb cycle): 2 cycles per transaction; 11 writes = 22 cycles; successful job with first poll done = 22 + 2 + 12 + 1 (DONE) cycles.
- `done` asserted one cycle in DONE; `busy` falls in the same cycle as `done`.
- `wb_ack_i` while cyc=0: ignored.
- `RST` mid-job: next edge returns to reset values, cyc/stb drop immediately; slave transaction abandoned; results cleared.

## Structure
- Package `ascon_wb_pkg`: address constants (ADDR_STATUS … ADDR_TAG0), `STATUS_DONE_BIT`, FSM state enum, write/read sequence lengths (11, 6).
- Sub-module `wb_single_xfer`: one-transaction engine (req/addr/data/we in, hold bus until ack, returns ack pulse + rdata); the top FSM sequences it and owns the gap cycle.

## Test plan
- Basic job: key 0x000102..0F, nonce same, ad=0x00010203_04000000, cntrl=0x3A80, zero-wait slave model → writes seen in order 0x08=0x0C0D0E0F, 0x0C=0x08090A0B, 0x10=0x04050607, 0x14=0x00010203, nonce likewise at 0x18–0x24, 0x28=0x04000000, 0x2C=0x00010203, 0x04=0x00003A80; `done`, `err`=0.
- Wait states: slave acks after 3 cycles each → bus signals stable across waits, one gap cycle per transaction, same write sequence.
- Polling: STATUS returns 0 three times then 1 → exactly 4 reads of 0x00, then 6 reads; `data_out`/`tag` equal model-returned values.
- Timeout: POLL_LIMIT=8, STATUS always 0 → 8 polls, `done`+`err`=1, no reads of 0x30+, results unchanged.
- `start` pulsed during WRITE and POLL → ignored, sequence unchanged, single `done`.
- `RST` asserted during the 5th write → next cycle cyc=stb=0, all outputs reset; new `start` runs a full clean job.

Source files
------------

// File: rtl/ascon_wb_pkg.sv
// Shared constants, state encoding and address helpers for the ASCON Wishbone initiator.
package ascon_wb_pkg;

  localparam logic [31:0] ADDR_STATUS = 32'h0000_0000;
  localparam logic [31:0] ADDR_CNTRL  = 32'h0000_0004;
  localparam logic [31:0] ADDR_KEY0   = 32'h0000_0008;
  localparam logic [31:0] ADDR_NONCE0 = 32'h0000_0018;
  localparam logic [31:0] ADDR_AD0    = 32'h0000_0028;
  localparam logic [31:0] ADDR_DOUT0  = 32'h0000_0030;
  localparam logic [31:0] ADDR_TAG0   = 32'h0000_0038;

  localparam int STATUS_DONE_BIT = 0;

  localparam logic [3:0] N_WRITES = 4'd11;
  localparam logic [2:0] N_READS  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WGAP,
    S_POLL,
    S_PGAP,
    S_READ,
    S_RGAP,
    S_DONE
  } state_t;

  // Write slot order: KEY0..3, NONCE0..3, AD0..1, then CNTRL last.
  function automatic logic [31:0] write_addr(input logic [3:0] idx);
    logic [31:0] a;
    case (idx)
      4'd0, 4'd1, 4'd2, 4'd3: a = ADDR_KEY0   + {28'd0, idx[1:0], 2'b00};
      4'd4, 4'd5, 4'd6, 4'd7: a = ADDR_NONCE0 + {28'd0, idx[1:0], 2'b00};
      4'd8, 4'd9:             a = ADDR_AD0    + {29'd0, idx[0], 2'b00};
      default:                a = ADDR_CNTRL;
    endcase
    return a;
  endfunction

  // Read slot order: DOUT0..1, then TAG0..3.
  function automatic logic [31:0] read_addr(input logic [2:0] idx);
    logic [1:0] t;
    logic [31:0] a;
    t = idx[1:0] - 2'd2;
    if (idx < 3'd2) a = ADDR_DOUT0 + {29'd0, idx[0], 2'b00};
    else            a = ADDR_TAG0  + {28'd0, t, 2'b00};
    return a;
  endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// Single Wishbone transaction engine: launches on req, holds the bus until ack.
module wb_single_xfer (
  input  logic        clk,
  input  logic        RST,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        ack,
  output logic [31:0] rdata,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i
);

  assign ack   = wb_cyc_o & wb_stb_o & wb_ack_i;
  assign rdata = wb_dat_i;

  // Drive a request onto the bus and keep it frozen until the slave acks, then release.
  always_ff @(posedge clk) begin
    if (RST || ack) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= 4'h0;
      wb_adr_o <= 32'h0;
      wb_dat_o <= 32'h0;
    end else if (req && !wb_cyc_o) begin
      wb_cyc_o <= 1'b1;
      wb_stb_o <= 1'b1;
      wb_we_o  <= we;
      wb_sel_o <= 4'hF;
      wb_adr_o <= addr;
      wb_dat_o <= we ? wdata : 32'h0;
    end
  end

endmodule

// File: rtl/wb_ascon_master.sv
// Sequences key/nonce/AD/control writes, STATUS polling and result readback on the ASCON slave.
module wb_ascon_master
  import ascon_wb_pkg::*;
#(
  parameter int POLL_LIMIT = 4096
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  input  logic [63:0]  ad,
  input  logic [15:0]  cntrl,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [63:0]  data_out,
  output logic [127:0] tag,
  output logic [31:0]  wb_adr_o,
  output logic [31:0]  wb_dat_o,
  output logic [3:0]   wb_sel_o,
  output logic         wb_we_o,
  output logic         wb_cyc_o,
  output logic         wb_stb_o,
  input  logic         wb_ack_i,
  input  logic [31:0]  wb_dat_i
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  state_t         state;
  logic [3:0]     widx;
  logic [2:0]     ridx;
  logic [PW-1:0]  poll_cnt;
  logic [PW-1:0]  poll_next;
  logic [127:0]   key_q;
  logic [127:0]   nonce_q;
  logic [63:0]    ad_q;
  logic [15:0]    cntrl_q;
  logic [31:0]    wr_word;
  logic [1:0]     tag_sel;

  logic           req;
  logic           xfer_we;
  logic           xfer_ack;
  logic [31:0]    xfer_addr;
  logic [31:0]    xfer_wdata;
  logic [31:0]    xfer_rdata;

  assign poll_next = poll_cnt + PW'(1);
  assign tag_sel   = ridx[1:0] - 2'd2;

  // Pick the 32-bit payload for the current write slot from the latched job inputs.
  always_comb begin
    wr_word = {16'd0, cntrl_q};
    case (widx)
      4'd0, 4'd1, 4'd2, 4'd3: wr_word = key_q[{widx[1:0], 5'd0} +: 32];
      4'd4, 4'd5, 4'd6, 4'd7: wr_word = nonce_q[{widx[1:0], 5'd0} +: 32];
      4'd8, 4'd9:             wr_word = ad_q[{widx[0], 5'd0} +: 32];
      default:                ;
    endcase
  end

  // Launch the next transaction from IDLE (on start) or from a gap state, so the bus idles exactly one cycle.
  always_comb begin
    req        = 1'b0;
    xfer_we    = 1'b0;
    xfer_addr  = 32'h0;
    xfer_wdata = 32'h0;
    case (state)
      S_IDLE: begin
        if (start) begin
          req        = 1'b1;
          xfer_we    = 1'b1;
          xfer_addr  = ADDR_KEY0;
          xfer_wdata = key[31:0];
        end
      end
      S_WGAP: begin
        req = 1'b1;
        if (widx == N_WRITES) begin
          xfer_addr = ADDR_STATUS;
        end else begin
          xfer_we    = 1'b1;
          xfer_addr  = write_addr(widx);
          xfer_wdata = wr_word;
        end
      end
      S_PGAP: begin
        req       = 1'b1;
        xfer_addr = ADDR_STATUS;
      end
      S_RGAP: begin
        if (ridx != N_READS) begin
          req       = 1'b1;
          xfer_addr = read_addr(ridx);
        end
      end
      default: ;
    endcase
  end

  wb_single_xfer u_xfer (
    .clk      (clk),
    .RST      (RST),
    .req      (req),
    .addr     (xfer_addr),
    .wdata    (xfer_wdata),
    .we       (xfer_we),
    .ack      (xfer_ack),
    .rdata    (xfer_rdata),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i),
    .wb_dat_i (wb_dat_i)
  );

  // Job sequencer: write phase, STATUS polling with timeout, result readback, one-cycle done.
  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= S_IDLE;
      widx     <= 4'd0;
      ridx     <= 3'd0;
      poll_cnt <= '0;
      key_q    <= 128'h0;
      nonce_q  <= 128'h0;
      ad_q     <= 64'h0;
      cntrl_q  <= 16'h0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      data_out <= 64'h0;
      tag      <= 128'h0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            key_q    <= key;
            nonce_q  <= nonce;
            ad_q     <= ad;
            cntrl_q  <= cntrl;
            widx     <= 4'd0;
            ridx     <= 3'd0;
            poll_cnt <= '0;
            busy     <= 1'b1;
            err      <= 1'b0;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (xfer_ack) begin
            widx  <= widx + 4'd1;
            state <= S_WGAP;
          end
        end
        S_WGAP: begin
          state <= (widx == N_WRITES) ? S_POLL : S_WRITE;
        end
        S_POLL: begin
          if (xfer_ack) begin
            if (xfer_rdata[STATUS_DONE_BIT]) begin
              state <= S_RGAP;
            end else begin
              poll_cnt <= poll_next;
              if (poll_next == PW'(POLL_LIMIT)) begin
                err   <= 1'b1;
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end else begin
                state <= S_PGAP;
              end
            end
          end
        end
        S_PGAP: begin
          state <= S_POLL;
        end
        S_READ: begin
          if (xfer_ack) begin
            if (ridx < 3'd2) data_out[{ridx[0], 5'd0} +: 32] <= xfer_rdata;
            else             tag[{tag_sel, 5'd0} +: 32]      <= xfer_rdata;
            ridx  <= ridx + 3'd1;
            state <= S_RGAP;
          end
        end
        S_RGAP: begin
          if (ridx == N_READS) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            state <= S_READ;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
